// File: rtl/pu_or1k_execute_ctrl_queue.sv
// Execute->ctrl boundary queue: DEPTH-entry in-order FIFO with late LSU
// exception merge into the head and a registered write-back port.
// Ports: clk, rst (sync, active-low), pipeline_flush_i, ex_* (push side,
// valid/ready), late_exc_i, ctrl_done_i, ctrl_* (head view), count_o,
// wb_* (registered retire), perf_* (stall counters).
// Optional: define OR1K_EXEC_CTRL_PERF_EN to build the perf counters.
`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

module pu_or1k_execute_ctrl_queue #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
    {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0},
  parameter int DEPTH  = 2,
  parameter int EXC_W  = 7,
  parameter int LATE_W = 4,
  parameter int OP_W   = 8,
  localparam int CW = $clog2(DEPTH+1),
  localparam int XW = EXC_W + LATE_W,
  localparam int OW = OPTION_OPERAND_WIDTH,
  localparam int AW = OPTION_RF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipeline_flush_i,
  input  logic          ex_valid_i,
  output logic          ex_ready_o,
  input  logic [OW-1:0] ex_pc_i,
  input  logic [OW-1:0] ex_result_i,
  input  logic [OW-1:0] ex_lsu_adr_i,
  input  logic [OW-1:0] ex_rfb_i,
  input  logic [AW-1:0] ex_rfd_adr_i,
  input  logic          ex_rf_wb_i,
  input  logic [OP_W-1:0] ex_op_i,
  input  logic [EXC_W-1:0] ex_exc_i,
  input  logic [LATE_W-1:0] late_exc_i,
  input  logic          ctrl_done_i,
  output logic          ctrl_valid_o,
  output logic [OW-1:0] ctrl_pc_o,
  output logic [OW-1:0] ctrl_result_o,
  output logic [OW-1:0] ctrl_lsu_adr_o,
  output logic [OW-1:0] ctrl_rfb_o,
  output logic [AW-1:0] ctrl_rfd_adr_o,
  output logic          ctrl_rf_wb_o,
  output logic [OP_W-1:0] ctrl_op_o,
  output logic [XW-1:0] ctrl_exc_o,
  output logic [CW-1:0] count_o,
  output logic          wb_valid_o,
  output logic          wb_rf_wb_o,
  output logic [AW-1:0] wb_rfd_adr_o,
  output logic [OW-1:0] wb_result_o,
  output logic [OW-1:0] wb_pc_o,
  output logic [XW-1:0] wb_exc_o,
  output logic [31:0]   perf_ctrl_stall_o,
  output logic [31:0]   perf_ex_block_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  // load, store and atomic flag positions
  localparam logic [OP_W-1:0] LSU_OPS = OP_W'(4'b1110);

  logic [OW-1:0]     pc_q   [DEPTH];
  logic [OW-1:0]     res_q  [DEPTH];
  logic [OW-1:0]     adr_q  [DEPTH];
  logic [OW-1:0]     rfb_q  [DEPTH];
  logic [AW-1:0]     rfd_q  [DEPTH];
  logic              wb_q   [DEPTH];
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [EXC_W-1:0]  exc_q  [DEPTH];
  logic [LATE_W-1:0] late_q [DEPTH];

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;

  logic              valid;
  logic              ready;
  logic              push;
  logic              pop;
  logic              merge;
  logic [LATE_W-1:0] late_m;
  logic [XW-1:0]     exc_m;
  logic              has_exc;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign valid = (count_q != '0);
  // full is decided from stored occupancy only, so ready never
  // depends on ctrl_done_i
  assign ready = (count_q != FULL);

  assign push  = ex_valid_i & ready & ~pipeline_flush_i;
  assign pop   = valid & ctrl_done_i & ~pipeline_flush_i;
  assign merge = valid & ~pipeline_flush_i;

  assign late_m  = late_q[rd_q] | (valid ? late_exc_i : '0);
  assign exc_m   = {late_m, exc_q[rd_q]};
  assign has_exc = |exc_m;

  assign ex_ready_o     = ready;
  assign ctrl_valid_o   = valid;
  assign ctrl_pc_o      = pc_q[rd_q];
  assign ctrl_result_o  = res_q[rd_q];
  assign ctrl_lsu_adr_o = adr_q[rd_q];
  assign ctrl_rfb_o     = rfb_q[rd_q];
  assign ctrl_rfd_adr_o = rfd_q[rd_q];
  assign ctrl_rf_wb_o   = valid & wb_q[rd_q];
  assign ctrl_op_o      = op_q[rd_q] & ~(has_exc ? LSU_OPS : '0);
  assign ctrl_exc_o     = exc_m;
  assign count_o        = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else if (pipeline_flush_i) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      if (push)
        wr_q <= nxt(wr_q);
      if (pop)
        rd_q <= nxt(rd_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // push slot and merged head never coincide: a push with a valid
  // head implies the queue is neither empty nor full
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= OPTION_RESET_PC;
        res_q[i]  <= '0;
        adr_q[i]  <= '0;
        rfb_q[i]  <= '0;
        rfd_q[i]  <= '0;
        wb_q[i]   <= 1'b0;
        op_q[i]   <= '0;
        exc_q[i]  <= '0;
        late_q[i] <= '0;
      end
    end else begin
      if (merge)
        late_q[rd_q] <= late_m;
      if (push) begin
        pc_q[wr_q]   <= ex_pc_i;
        res_q[wr_q]  <= ex_result_i;
        adr_q[wr_q]  <= ex_lsu_adr_i;
        rfb_q[wr_q]  <= ex_rfb_i;
        rfd_q[wr_q]  <= ex_rfd_adr_i;
        wb_q[wr_q]   <= ex_rf_wb_i;
        op_q[wr_q]   <= ex_op_i;
        exc_q[wr_q]  <= ex_exc_i;
        late_q[wr_q] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_o   <= 1'b0;
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      wb_result_o  <= '0;
      wb_pc_o      <= '0;
      wb_exc_o     <= '0;
    end else if (pop) begin
      wb_valid_o   <= 1'b1;
      wb_rf_wb_o   <= wb_q[rd_q] & ~has_exc;
      wb_rfd_adr_o <= rfd_q[rd_q];
      wb_result_o  <= res_q[rd_q];
      wb_pc_o      <= pc_q[rd_q];
      wb_exc_o     <= exc_m;
    end else begin
      wb_valid_o   <= 1'b0;
      wb_rf_wb_o   <= 1'b0;
    end
  end

`ifdef OR1K_EXEC_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] block_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      block_q <= '0;
    end else begin
      if (valid & ~ctrl_done_i & (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (ex_valid_i & ~ready & (block_q != '1))
        block_q <= block_q + 32'd1;
    end
  end

  assign perf_ctrl_stall_o = stall_q;
  assign perf_ex_block_o   = block_q;
`else
  assign perf_ctrl_stall_o = 32'd0;
  assign perf_ex_block_o   = 32'd0;
`endif

endmodule

// File: tb/tb_pu_or1k_execute_ctrl_queue.sv
// Randomised scoreboard bench for pu_or1k_execute_ctrl_queue (DEPTH=3).
// Queue-of-records reference model; retire checks run in a monitor.
module tb_pu_or1k_execute_ctrl_queue;

  localparam int D  = 3;
  localparam int XW = 11;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef OR1K_EXEC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pipeline_flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_pc_i, ex_result_i, ex_lsu_adr_i, ex_rfb_i;
  logic [4:0]  ex_rfd_adr_i;
  logic        ex_rf_wb_i;
  logic [7:0]  ex_op_i;
  logic [6:0]  ex_exc_i;
  logic [3:0]  late_exc_i;
  logic        ctrl_done_i;
  logic        ctrl_valid_o;
  logic [31:0] ctrl_pc_o, ctrl_result_o, ctrl_lsu_adr_o, ctrl_rfb_o;
  logic [4:0]  ctrl_rfd_adr_o;
  logic        ctrl_rf_wb_o;
  logic [7:0]  ctrl_op_o;
  logic [XW-1:0] ctrl_exc_o;
  logic [1:0]  count_o;
  logic        wb_valid_o, wb_rf_wb_o;
  logic [4:0]  wb_rfd_adr_o;
  logic [31:0] wb_result_o, wb_pc_o;
  logic [XW-1:0] wb_exc_o;
  logic [31:0] perf_ctrl_stall_o, perf_ex_block_o;

  pu_or1k_execute_ctrl_queue #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5),
    .OPTION_RESET_PC(RST_PC),
    .DEPTH(D),
    .EXC_W(7),
    .LATE_W(4),
    .OP_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pipeline_flush_i(pipeline_flush_i),
    .ex_valid_i(ex_valid_i),
    .ex_ready_o(ex_ready_o),
    .ex_pc_i(ex_pc_i),
    .ex_result_i(ex_result_i),
    .ex_lsu_adr_i(ex_lsu_adr_i),
    .ex_rfb_i(ex_rfb_i),
    .ex_rfd_adr_i(ex_rfd_adr_i),
    .ex_rf_wb_i(ex_rf_wb_i),
    .ex_op_i(ex_op_i),
    .ex_exc_i(ex_exc_i),
    .late_exc_i(late_exc_i),
    .ctrl_done_i(ctrl_done_i),
    .ctrl_valid_o(ctrl_valid_o),
    .ctrl_pc_o(ctrl_pc_o),
    .ctrl_result_o(ctrl_result_o),
    .ctrl_lsu_adr_o(ctrl_lsu_adr_o),
    .ctrl_rfb_o(ctrl_rfb_o),
    .ctrl_rfd_adr_o(ctrl_rfd_adr_o),
    .ctrl_rf_wb_o(ctrl_rf_wb_o),
    .ctrl_op_o(ctrl_op_o),
    .ctrl_exc_o(ctrl_exc_o),
    .count_o(count_o),
    .wb_valid_o(wb_valid_o),
    .wb_rf_wb_o(wb_rf_wb_o),
    .wb_rfd_adr_o(wb_rfd_adr_o),
    .wb_result_o(wb_result_o),
    .wb_pc_o(wb_pc_o),
    .wb_exc_o(wb_exc_o),
    .perf_ctrl_stall_o(perf_ctrl_stall_o),
    .perf_ex_block_o(perf_ex_block_o)
  );

  typedef struct {
    logic [31:0] pc, res, adr, rfb;
    logic [4:0]  rfd;
    logic        wb;
    logic [7:0]  op;
    logic [6:0]  exc;
    logic [3:0]  late;
  } ent_t;

  typedef struct {
    logic [31:0]   pc, res;
    logic [4:0]    rfd;
    logic          wb;
    logic [XW-1:0] exc;
  } ret_t;

  ent_t mq[$];
  ret_t sb[$];
  logic [31:0] ps = 0, pb = 0;
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input logic v, input logic d, input logic f,
                     input logic [3:0] le, input logic [31:0] pc,
                     input logic [7:0] op, input logic wb,
                     input logic [6:0] ex);
    ex_valid_i = v;
    ctrl_done_i = d;
    pipeline_flush_i = f;
    late_exc_i = le;
    ex_pc_i = pc;
    ex_op_i = op;
    ex_rf_wb_i = wb;
    ex_exc_i = ex;
    ex_result_i = $urandom;
    ex_lsu_adr_i = $urandom;
    ex_rfb_i = $urandom;
    ex_rfd_adr_i = 5'($urandom);
  endtask

  // compare head view, advance model one clock, return at next negedge
  task automatic tick();
    logic v, rdy, hwb;
    logic [3:0] lm;
    logic [XW-1:0] xm;
    logic [7:0] opx;
    ent_t h, n;
    #1;
    v = (mq.size() != 0);
    rdy = (mq.size() != D);
    hwb = 1'b0;
    xm = '0;
    chk("ctrl_valid", ctrl_valid_o, v);
    chk("ex_ready", ex_ready_o, rdy);
    chk("count", count_o, mq.size());
    if (v) begin
      h = mq[0];
      hwb = h.wb;
      lm = h.late | late_exc_i;
      xm = {lm, h.exc};
      opx = (xm != 0) ? (h.op & 8'hF1) : h.op;
      chk("ctrl_pc", ctrl_pc_o, h.pc);
      chk("ctrl_result", ctrl_result_o, h.res);
      chk("ctrl_lsu_adr", ctrl_lsu_adr_o, h.adr);
      chk("ctrl_rfb", ctrl_rfb_o, h.rfb);
      chk("ctrl_rfd", ctrl_rfd_adr_o, h.rfd);
      chk("ctrl_exc", ctrl_exc_o, xm);
      chk("ctrl_op", ctrl_op_o, opx);
    end
    chk("ctrl_rf_wb", ctrl_rf_wb_o, hwb);
    chk("perf_stall", perf_ctrl_stall_o, PERF ? ps : 32'd0);
    chk("perf_block", perf_ex_block_o, PERF ? pb : 32'd0);
    if (!rst) begin
      mq.delete();
      ps = 0;
      pb = 0;
    end else begin
      if (v && !ctrl_done_i && ps != 32'hFFFF_FFFF) ps++;
      if (ex_valid_i && !rdy && pb != 32'hFFFF_FFFF) pb++;
      if (pipeline_flush_i) mq.delete();
      else begin
        if (v) begin
          if (ctrl_done_i) begin
            sb.push_back('{pc: h.pc, res: h.res, rfd: h.rfd,
                           wb: h.wb && (xm == 0), exc: xm});
            void'(mq.pop_front());
          end else mq[0].late = lm;
        end
        if (ex_valid_i && rdy) begin
          n.pc = ex_pc_i; n.res = ex_result_i; n.adr = ex_lsu_adr_i;
          n.rfb = ex_rfb_i; n.rfd = ex_rfd_adr_i; n.wb = ex_rf_wb_i;
          n.op = ex_op_i; n.exc = ex_exc_i; n.late = '0;
          mq.push_back(n);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    ret_t r;
    if (wb_valid_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got retire pc %0h expected none",
                 wb_pc_o);
      end else begin
        r = sb.pop_front();
        chk("wb_pc", wb_pc_o, r.pc);
        chk("wb_result", wb_result_o, r.res);
        chk("wb_rfd", wb_rfd_adr_o, r.rfd);
        chk("wb_rf_wb", wb_rf_wb_o, r.wb);
        chk("wb_exc", wb_exc_o, r.exc);
      end
    end else begin
      chk("wb_rf_wb_idle", wb_rf_wb_o, 1'b0);
    end
  end

  initial begin
    rst = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    chk("rst_valid", ctrl_valid_o, 0);
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_pc", ctrl_pc_o, RST_PC);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_pc", wb_pc_o, 0);

    // fill to full, blocked push while popping, ordered drain
    put(1, 0, 0, 0, 32'h100, 8'h01, 1, 0); tick();
    put(1, 0, 0, 0, 32'h104, 8'h00, 1, 0); tick();
    put(1, 0, 0, 0, 32'h108, 8'h00, 0, 0); tick();
    chk("full_ready", ex_ready_o, 0);
    put(1, 1, 0, 0, 32'h10c, 8'h00, 1, 0); tick();
    put(0, 1, 0, 0, 0, 0, 0, 0); tick();
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // back-to-back push+pop across the pointer wrap
    put(1, 0, 0, 0, 32'h1fc, 8'h00, 1, 0); tick();
    for (int i = 0; i < 10; i++) begin
      put(1, 1, 0, 0, 32'h200 + 32'(4*i), 8'h00, 1, 0);
      tick();
      chk("wrap_count", count_o, 1);
    end
    put(0, 1, 0, 0, 0, 0, 0, 0); tick();

    // late LSU exception on a load head
    put(1, 0, 0, 0, 32'h300, 8'h02, 1, 0); tick();
    put(0, 0, 0, 4'b0001, 0, 0, 0, 0); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("late_load_masked", ctrl_op_o[1], 0);
    tick();
    put(0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("late_wb_valid", wb_valid_o, 1);
    chk("late_wb_exc7", wb_exc_o[7], 1);
    chk("late_wb_rf_wb", wb_rf_wb_o, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // flush beats a simultaneous push and pop
    put(1, 0, 0, 0, 32'h400, 8'h00, 1, 0); tick();
    put(1, 0, 0, 0, 32'h404, 8'h00, 1, 0); tick();
    put(1, 1, 1, 4'hf, 32'h408, 8'h00, 1, 0); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_count", count_o, 0);
    chk("flush_wb_valid", wb_valid_o, 0);
    tick();

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      put($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0,
          ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
          $urandom, 8'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h0);
      tick();
    end
    rst = 1'b1;

    // reset mid-stream with two entries queued
    put(0, 0, 1, 0, 0, 0, 0, 0); tick();
    put(1, 0, 0, 0, 32'h500, 8'h00, 1, 0); tick();
    put(1, 0, 0, 0, 32'h504, 8'h00, 1, 0); tick();
    chk("mid_count", count_o, 2);
    rst = 1'b0;
    put(1, 1, 1, 0, 32'h508, 8'h00, 1, 0); tick();
    rst = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_valid", ctrl_valid_o, 0);
    chk("mid_wb_rf_wb", wb_rf_wb_o, 0);
    chk("mid_pc", ctrl_pc_o, RST_PC);
    tick();

    // perf: 5 stalled-head cycles, 3 blocked-execute cycles
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(1, 0, 0, 0, 32'h600 + 32'(4*i), 8'h00, 1, 0);
      tick();
    end
    put(0, 1, 0, 0, 0, 0, 0, 0);
    chk("perf_stall5", perf_ctrl_stall_o, PERF ? 32'd5 : 32'd0);
    chk("perf_block3", perf_ex_block_o, PERF ? 32'd3 : 32'd0);
    tick(); tick(); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
